data_mem_responder: RTL

//   Memory-side responder for CPU load/store traffic. Accepts one request at a

---
 rtl/data_mem_responder.sv | 122 ++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// Multi-cycle data memory responder: one request at a time, LATENCY wait states,
// response held until consumed. Optional DMEM_ALIGN_CHECK_EN flags misaligned/out-of-range accesses.
module data_mem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_write,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [1:0]  dbg_state
);

  // Handshake: a request transfers on an edge where req_valid && req_ready;
  // a response transfers on an edge where resp_valid && resp_ready. resp_*
  // payload is held stable while resp_valid is high and resp_ready is low.

  localparam int AW = $clog2(DEPTH);
  localparam bit ZERO_LAT = (LATENCY == 0);
  localparam logic [3:0] CNT_INIT = ZERO_LAT ? 4'd0 : 4'(LATENCY - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        write_q;
  logic [31:0] mem [DEPTH];

  logic          accept;
  logic          enter_resp;
  logic [31:0]   acc_addr;
  logic [31:0]   acc_wdata;
  logic          acc_write;
  logic [AW-1:0] acc_idx;
  logic          acc_err;
  logic          unused_bits;

  assign req_ready = (state == IDLE);
  assign dbg_state = state;
  assign accept    = req_valid && req_ready;

  // With zero latency the access executes on the accept edge itself, so it
  // must use the live request rather than the not-yet-latched copy.
  assign enter_resp = (accept && ZERO_LAT) || (state == WAIT && cnt == 4'd0);
  assign acc_addr   = (state == IDLE) ? req_addr  : addr_q;
  assign acc_wdata  = (state == IDLE) ? req_wdata : wdata_q;
  assign acc_write  = (state == IDLE) ? req_write : write_q;
  assign acc_idx    = acc_addr[AW+1:2];
  assign unused_bits = ^{acc_addr[31:AW+2], acc_addr[1:0]};

`ifdef DMEM_ALIGN_CHECK_EN
  assign acc_err = (acc_addr[1:0] != 2'b00) || ((acc_addr >> (AW + 2)) != 32'd0);
`else
  assign acc_err = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      write_q    <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            write_q <= req_write;
            if (ZERO_LAT) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) state <= RESP;
          else             cnt   <= cnt - 4'd1;
        end
        RESP: begin
          if (resp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (enter_resp) begin
        resp_valid <= 1'b1;
        resp_err   <= acc_err;
        resp_rdata <= (!acc_write && !acc_err) ? mem[acc_idx] : 32'd0;
      end else if (state == RESP && resp_ready) begin
        resp_valid <= 1'b0;
        resp_rdata <= 32'd0;
        resp_err   <= 1'b0;
      end
    end
  end

  // Array has no reset; it is only written on the edge entering RESP.
  always_ff @(posedge clock) begin
    if (reset && enter_resp && acc_write && !acc_err) begin
      mem[acc_idx] <= acc_wdata;
    end
  end

endmodule
